hex_display_scanner: RTL and testbench



---
 rtl/hex_display_scanner.sv | 195 +++++++++++++++++++
 tb/tb_hex_display_scanner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scanner.sv
`default_nettype none
// ============================================================================
// hex_display_scanner : time-multiplexed multi-digit hex to 7-segment driver
// Revision            : 1.0
// ============================================================================
module hex_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD      = 2,
  parameter int BLINK_DIV  = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    load_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blink_i,
  input  logic                    lzb_i,
  input  logic                    enable_i,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_o
);

  localparam int c_val_w = 4 * NUM_DIGITS;
  localparam int c_cnt_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_blk_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [NUM_DIGITS-1:0] c_digit_one = NUM_DIGITS'(1);

  logic [c_cnt_w-1:0]    scan_cnt_q, scan_cnt_d;
  logic [c_idx_w-1:0]    idx_q, idx_d;
  logic [c_val_w-1:0]    act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0] act_blink_q, act_blink_d, pend_blink_q, pend_blink_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [c_blk_w-1:0]    blink_cnt_q, blink_cnt_d;
  logic                  blink_on_q, blink_on_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_q, frame_d;

  logic                  w_slot_end, w_last_digit, w_boundary;
  logic                  w_guard_ok, w_digit_on;
  logic [3:0]            w_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_lz_blank, w_blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h7E;
      4'h1: hex_to_seg = 7'h30;
      4'h2: hex_to_seg = 7'h6D;
      4'h3: hex_to_seg = 7'h79;
      4'h4: hex_to_seg = 7'h33;
      4'h5: hex_to_seg = 7'h5B;
      4'h6: hex_to_seg = 7'h5F;
      4'h7: hex_to_seg = 7'h70;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h7B;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h1F;
      4'hC: hex_to_seg = 7'h4E;
      4'hD: hex_to_seg = 7'h3D;
      4'hE: hex_to_seg = 7'h4F;
      default: hex_to_seg = 7'h47;
    endcase
  endfunction

  assign w_slot_end   = (scan_cnt_q == c_cnt_w'(SCAN_DIV - 1));
  assign w_last_digit = (idx_q == c_idx_w'(NUM_DIGITS - 1));
  assign w_boundary   = w_slot_end & w_last_digit;

  generate
    if (GUARD == 0) begin : g_guard_none
      assign w_guard_ok = 1'b1;
    end else begin : g_guard_cmp
      assign w_guard_ok = (scan_cnt_q >= c_cnt_w'(GUARD));
    end
  endgenerate

  // A digit is LZ-blanked when it and every digit above it hold zero.
  generate
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
      assign w_nib[k] = act_val_q[4*k +: 4];
      if (k == 0) begin : g_lsd
        assign w_lz_blank[k] = 1'b0;
      end else begin : g_upper
        assign w_lz_blank[k] = lzb_i & ~(|act_val_q[c_val_w-1:4*k]);
      end
      assign w_blank[k] = w_lz_blank[k] | (act_blink_q[k] & ~blink_on_q);
    end
  endgenerate

  assign w_digit_on = w_guard_ok & enable_i & ~w_blank[idx_q];

  always_comb begin
    scan_cnt_d   = w_slot_end ? '0 : scan_cnt_q + c_cnt_w'(1);
    idx_d        = idx_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_blink_d  = act_blink_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blink_d = pend_blink_q;
    pend_valid_d = pend_valid_q;
    blink_cnt_d  = blink_cnt_q;
    blink_on_d   = blink_on_q;

    if (w_slot_end) begin
      idx_d = w_last_digit ? '0 : idx_q + c_idx_w'(1);
    end

    // A load landing on the boundary itself goes straight to the active set.
    if (w_boundary) begin
      if (load_i) begin
        act_val_d   = value_i;
        act_dp_d    = dp_i;
        act_blink_d = blink_i;
      end else if (pend_valid_q) begin
        act_val_d   = pend_val_q;
        act_dp_d    = pend_dp_q;
        act_blink_d = pend_blink_q;
      end
      pend_valid_d = 1'b0;
      if (blink_cnt_q == c_blk_w'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + c_blk_w'(1);
      end
    end else if (load_i) begin
      pend_val_d   = value_i;
      pend_dp_d    = dp_i;
      pend_blink_d = blink_i;
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    an_d    = '1;
    frame_d = w_boundary;
    if (w_digit_on) begin
      an_d  = ~(c_digit_one << idx_q);
      seg_d = ~hex_to_seg(w_nib[idx_q]);
      dp_d  = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q   <= '0;
      idx_q        <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blink_q  <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blink_q <= '0;
      pend_valid_q <= 1'b0;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_q      <= 1'b0;
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      idx_q        <= idx_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_blink_q  <= act_blink_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blink_q <= pend_blink_d;
      pend_valid_q <= pend_valid_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_q      <= frame_d;
    end
  end

  assign seg_n   = seg_q;
  assign dp_n    = dp_q;
  assign an_n    = an_q;
  assign frame_o = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
`default_nettype none
// ============================================================================
// tb_hex_display_scanner : frame-level scoreboard bench for hex_display_scanner
// Revision               : 1.0
// ============================================================================
module tb_hex_display_scanner;

  localparam logic [11:0] OFF = 12'hFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value_i = '0;
  logic        load_i = 1'b0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  blink_i = '0;
  logic        lzb_i = 1'b0;
  logic        enable_i = 1'b1;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_o;

  hex_display_scanner #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .GUARD(1), .BLINK_DIV(2)
  ) u_dut (
    .clk(clk), .reset(reset), .value_i(value_i), .load_i(load_i),
    .dp_i(dp_i), .blink_i(blink_i), .lzb_i(lzb_i), .enable_i(enable_i),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  // Expected per-digit output {an_n, seg_n, dp_n} for one whole frame.
  typedef struct packed {
    int          tag;
    logic [47:0] slots;
  } rec_t;

  rec_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fnum  = 0;
  int   pos   = 0;

  logic [6:0] pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  function automatic rec_t mk(input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input logic [3:0] lit, input logic [3:0] dp);
    rec_t       r;
    logic [6:0] s [4];
    s = '{s0, s1, s2, s3};
    r.tag = 0;
    for (int d = 0; d < 4; d++)
      r.slots[12*d +: 12] = lit[d] ? {~(4'b0001 << d), ~s[d], ~dp[d]} : OFF;
    return r;
  endfunction

  // Monitor: frame_o (or reset release) opens a frame; each slot is a guard cycle
  // followed by three lit cycles, with the last one coinciding with the next frame_o.
  always @(negedge clk) begin : monitor
    logic [11:0] obs;
    int          d;
    int          p;
    static bit   was_rst = 1'b1;
    static bit   cur_v   = 1'b0;
    static int   cyc     = 0;
    static rec_t cur;
    obs = {an_n, seg_n, dp_n};
    if (reset) begin
      was_rst = 1'b1;
      cur_v   = 1'b0;
      fnum    = 0;
      cyc     = 0;
    end else if (was_rst || frame_o) begin
      if (!was_rst) begin
        if (cur_v) begin
          chk($sformatf("f%0d d3 last", fnum), obs, cur.slots[47:36]);
          chk($sformatf("f%0d frame period", fnum), 12'(cyc), 12'd15);
        end
        fnum++;
      end
      was_rst = 1'b0;
      cyc     = 0;
      cur_v   = 1'b0;
      while (q.size() > 0 && q[0].tag < fnum) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed frame: got frame %0d want frame %0d", fnum, q[0].tag);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].tag == fnum) begin
        cur   = q.pop_front();
        cur_v = 1'b1;
      end
    end else begin
      cyc++;
      if (cur_v) begin
        if (cyc > 15) begin
          chk($sformatf("f%0d frame_o missing", fnum), 12'(frame_o), 12'd1);
          cur_v = 1'b0;
        end else begin
          d = (cyc - 1) / 4;
          p = (cyc - 1) % 4;
          if (p == 0)
            chk($sformatf("f%0d d%0d guard", fnum, d), obs, OFF);
          else
            chk($sformatf("f%0d d%0d c%0d", fnum, d, cyc), obs, cur.slots[12*d +: 12]);
        end
      end
    end
  end

  task automatic expect_next(input rec_t e);
    e.tag = fnum + 1;
    q.push_back(e);
  endtask

  task automatic load_at(input int k, input logic [15:0] v,
                         input logic [3:0] dp, input logic [3:0] bl);
    repeat (k - pos) @(posedge clk);
    @(negedge clk);
    value_i = v;
    dp_i    = dp;
    blink_i = bl;
    load_i  = 1'b1;
    @(posedge clk);
    #1 load_i = 1'b0;
    pos = k + 1;
  endtask

  // Live controls change on the frame_o cycle so they cover the whole new frame.
  task automatic next_frame(input logic lzb, input logic en);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_o && n < 40);
    if (!frame_o) begin
      chk("frame_o timeout", 12'(frame_o), 12'd1);
      finish_run();
    end
    lzb_i    = lzb;
    enable_i = en;
    @(posedge clk);
    pos = 1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.push_back(mk(7'h7E, 7'h7E, 7'h7E, 7'h7E, 4'hF, 4'h0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {an_n, seg_n, dp_n}, OFF);
    chk("reset frame_o", 12'(frame_o), 12'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    pos = 1;
  endtask

  initial begin
    #100000;
    chk("watchdog", 12'd1, 12'd0);
    finish_run();
  end

  initial begin
    do_reset();
    // frame 0 shows 0000; frame 1 shows 1234 with dp on digit 2
    expect_next(mk(7'h30, 7'h6D, 7'h79, 7'h33, 4'hF, 4'b0100));
    load_at(5, 16'h1234, 4'b0100, 4'b0000);
    next_frame(1'b0, 1'b1);
    // decode sweep on digit 0, one nibble per frame, some via boundary bypass
    for (int i = 0; i < 16; i++) begin
      expect_next(mk(7'h7E, 7'h7E, 7'h7E, pat[i], 4'hF, 4'h0));
      load_at((i % 4 == 3) ? 15 : 1 + (i % 13), {12'h000, 4'(i)}, 4'h0, 4'h0);
      next_frame(1'b0, 1'b1);
    end
    // double buffer: last load in a frame wins, AAAA never shown
    expect_next(mk(7'h5B, 7'h5B, 7'h5B, 7'h5B, 4'hF, 4'h0));
    load_at(3, 16'hAAAA, 4'h0, 4'h0);
    load_at(10, 16'h5555, 4'h0, 4'h0);
    next_frame(1'b0, 1'b1);
    expect_next(mk(7'h5B, 7'h5B, 7'h5B, 7'h5B, 4'hF, 4'h0));
    next_frame(1'b0, 1'b1);
    // load exactly in the boundary cycle
    expect_next(mk(7'h7E, 7'h7E, 7'h47, 7'h7E, 4'hF, 4'h0));
    load_at(15, 16'h00F0, 4'h0, 4'h0);
    next_frame(1'b0, 1'b1);
    // leading-zero blanking
    expect_next(mk(7'h7E, 7'h7E, 7'h70, 7'h7E, 4'b0011, 4'h0));
    load_at(7, 16'h0070, 4'h0, 4'h0);
    next_frame(1'b1, 1'b1);
    expect_next(mk(7'h7E, 7'h7E, 7'h7E, 7'h7E, 4'b0001, 4'h0));
    load_at(2, 16'h0000, 4'h0, 4'h0);
    next_frame(1'b1, 1'b1);
    expect_next(mk(7'h7E, 7'h30, 7'h7E, 7'h6D, 4'b0111, 4'h0));
    load_at(9, 16'h0102, 4'h0, 4'h0);
    next_frame(1'b1, 1'b1);
    // enable off blanks a whole frame, scan keeps running
    expect_next(mk(7'h7E, 7'h30, 7'h7E, 7'h6D, 4'b0000, 4'h0));
    next_frame(1'b1, 1'b0);
    expect_next(mk(7'h7E, 7'h30, 7'h7E, 7'h6D, 4'hF, 4'h0));
    next_frame(1'b0, 1'b1);
    // mid-frame reset
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid-frame reset outputs", {an_n, seg_n, dp_n}, OFF);
    chk("mid-frame reset frame_o", 12'(frame_o), 12'd0);
    // blink on digit 0: lit frames 0-1, dark 2-3, lit 4-5
    do_reset();
    expect_next(mk(7'h7E, 7'h7E, 7'h7E, 7'h7F, 4'hF, 4'b0001));
    load_at(4, 16'h0008, 4'b0001, 4'b0001);
    next_frame(1'b0, 1'b1);
    expect_next(mk(7'h7E, 7'h7E, 7'h7E, 7'h7F, 4'b1110, 4'b0001));
    next_frame(1'b0, 1'b1);
    expect_next(mk(7'h7E, 7'h7E, 7'h7E, 7'h7F, 4'b1110, 4'b0001));
    next_frame(1'b0, 1'b1);
    expect_next(mk(7'h7E, 7'h7E, 7'h7E, 7'h7F, 4'hF, 4'b0001));
    next_frame(1'b0, 1'b1);
    expect_next(mk(7'h7E, 7'h7E, 7'h7E, 7'h7F, 4'hF, 4'b0001));
    next_frame(1'b0, 1'b1);
    next_frame(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 12'(q.size()), 12'd0);
    finish_run();
  end

endmodule
`default_nettype wire
